// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: owner encoding and default geometry shared by the data-memory arbiter files
package dmem_arb_pkg;
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF = 2'd1;
    localparam logic [1:0] OWN_MEM = 2'd2;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: 2-way one-hot picker, gnt[0]=IF gnt[1]=MEM, prio_if breaks a tie toward IF
module dmem_arb_pick (
    input  logic [1:0] reqs,
    input  logic       prio_if,
    output logic [1:0] gnt
);
    always_comb gnt = {reqs[1] & (~reqs[0] | ~prio_if), reqs[0] & (~reqs[1] | prio_if)};
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one 1-cycle-latency data RAM between IF and MEM; DMEM_ARB_RR_EN selects round-robin
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    logic [1:0] owner;
    logic [1:0] gnt;
    logic       prio_if;
    logic       unused_addr;
    assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2], mem_addr[1:0]};
    dmem_arb_pick u_pick (.reqs({mem_req, if_req}), .prio_if(prio_if), .gnt(gnt));
`ifdef DMEM_ARB_RR_EN
    logic rr_ptr;
    assign prio_if = rr_ptr;
    always_ff @(posedge clk)
        if (reset) rr_ptr <= 1'b0;
        else if (if_req && mem_req) rr_ptr <= ~rr_ptr;
`else
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] wait_cnt;
    assign prio_if = (wait_cnt == CW'(MAX_WAIT));
    always_ff @(posedge clk)
        if (reset || !if_req || if_gnt) wait_cnt <= '0;
        else if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + CW'(1);
`endif
    always_ff @(posedge clk)
        if (reset) owner <= OWN_NONE;
        else owner <= if_gnt ? OWN_IF : (mem_gnt && !mem_we) ? OWN_MEM : OWN_NONE;
    // everything is gated by reset so a pending read or a write in the reset cycle never escapes
    always_comb begin
        if_gnt = gnt[0] & ~reset;
        mem_gnt = gnt[1] & ~reset;
        stall_if = if_req & ~if_gnt & ~reset;
        stall_mem = mem_req & ~mem_gnt & ~reset;
        if_rvalid = (owner == OWN_IF) & ~reset;
        mem_rvalid = (owner == OWN_MEM) & ~reset;
        if_rdata = if_rvalid ? ram_rdata : '0;
        mem_rdata = mem_rvalid ? ram_rdata : '0;
        ram_en = if_gnt | mem_gnt;
        ram_we = mem_gnt & mem_we;
        ram_addr = mem_gnt ? mem_addr[ADDR_W+1:2] : if_gnt ? if_addr[ADDR_W+1:2] : '0;
        ram_wdata = ram_we ? mem_wdata : '0;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed vector table plus contention and reset sequences against a RAM model
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, stall_if, stall_mem, ram_en, ram_we;
    logic [31:0] if_rdata, mem_rdata, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [9:0]  ram_addr;
    logic [31:0] ram [0:1023];
    int checks = 0, errors = 0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req, mem_we;
        logic [31:0] mem_addr, mem_wdata;
        logic        if_gnt, mem_gnt, if_rvalid, mem_rvalid;
        logic [31:0] if_rdata, mem_rdata;
        logic        ram_en, ram_we;
        logic [9:0]  ram_addr;
    } vec_t;
    vec_t vecs [10];

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else ram_rdata <= ram[ram_addr];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                         input logic [31:0] ma, input logic [31:0] md);
        if_req = ir; if_addr = ia; mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = md;
    endtask

    initial begin
        logic e_if;
        logic [1:0] prev;
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        ram[5] = 32'hDEADBEEF;
        vecs[0] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd5};
        vecs[1] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 10'd0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 10'd8};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd8};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 1'b0, 10'd0};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF1017, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd5};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 10'd0};
        vecs[7] = '{1'b1, 32'h80001016, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd5};
        vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 10'd8};
        vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h12345678, 1'b0, 1'b0, 10'd0};

        drive(1'b1, 32'h14, 1'b1, 1'b1, 32'h40, 32'hBAD);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_if_gnt", if_gnt, 0);
            chk("rst_mem_gnt", mem_gnt, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_if_rvalid", if_rvalid, 0);
            chk("rst_mem_rvalid", mem_rvalid, 0);
            chk("rst_stall_if", stall_if, 0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        #1;
        chk("post_rst_if_rvalid", if_rvalid, 0);
        chk("post_rst_mem_rvalid", mem_rvalid, 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].mem_req, vecs[i].mem_we, vecs[i].mem_addr, vecs[i].mem_wdata);
            #1;
            chk($sformatf("v%0d_if_gnt", i), if_gnt, vecs[i].if_gnt);
            chk($sformatf("v%0d_mem_gnt", i), mem_gnt, vecs[i].mem_gnt);
            chk($sformatf("v%0d_if_rvalid", i), if_rvalid, vecs[i].if_rvalid);
            chk($sformatf("v%0d_mem_rvalid", i), mem_rvalid, vecs[i].mem_rvalid);
            chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].if_rdata);
            chk($sformatf("v%0d_mem_rdata", i), mem_rdata, vecs[i].mem_rdata);
            chk($sformatf("v%0d_ram_en", i), ram_en, vecs[i].ram_en);
            chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].ram_we);
            chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].ram_addr);
            chk($sformatf("v%0d_stall_if", i), stall_if, vecs[i].if_req & ~vecs[i].if_gnt);
            chk($sformatf("v%0d_stall_mem", i), stall_mem, vecs[i].mem_req & ~vecs[i].mem_gnt);
            tick();
        end

        prev = 2'd0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 32'h14, 1'b1, 1'b0, 32'h20, 0);
            #1;
`ifdef DMEM_ARB_RR_EN
            e_if = (k % 2) == 1;
`else
            e_if = (k % 4) == 3;
`endif
            chk($sformatf("c%0d_if_gnt", k), if_gnt, e_if);
            chk($sformatf("c%0d_mem_gnt", k), mem_gnt, !e_if);
            chk($sformatf("c%0d_stall_if", k), stall_if, !e_if);
            chk($sformatf("c%0d_stall_mem", k), stall_mem, e_if);
            chk($sformatf("c%0d_if_rvalid", k), if_rvalid, prev == 2'd1);
            chk($sformatf("c%0d_mem_rvalid", k), mem_rvalid, prev == 2'd2);
            chk($sformatf("c%0d_if_rdata", k), if_rdata, prev == 2'd1 ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("c%0d_mem_rdata", k), mem_rdata, prev == 2'd2 ? 32'h12345678 : 32'h0);
            prev = e_if ? 2'd1 : 2'd2;
            tick();
        end
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        tick();

        drive(1'b0, 0, 1'b1, 1'b0, 32'h20, 0);
        #1;
        chk("r6_mem_gnt", mem_gnt, 1);
        tick();
        reset = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b1, 32'h40, 32'hBAD);
        #1;
        chk("r6_mem_rvalid_in_rst", mem_rvalid, 0);
        chk("r6_mem_rdata_in_rst", mem_rdata, 0);
        chk("r6_wr_gnt_in_rst", mem_gnt, 0);
        chk("r6_ram_en_in_rst", ram_en, 0);
        tick();
        reset = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0, 0, 0);
        #1;
        chk("r6_mem_rvalid_after", mem_rvalid, 0);
        chk("r6_if_rvalid_after", if_rvalid, 0);
        chk("r6_write_suppressed", ram[16], 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
